// File: rtl/sbus_pkg.sv
// ============================================================================
// Module   : sbus_pkg
// Purpose  : Shared S.Bus frame constants, FSM state type and byte map helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sbus_pkg;

    localparam logic [7:0] SBUS_HEADER      = 8'h0F;
    localparam logic [7:0] SBUS_FOOTER      = 8'h00;
    localparam int         SBUS_FRAME_BYTES = 25;
    localparam int         SBUS_CH_BITS     = 11;
    localparam int         SBUS_NUM_CH      = 16;
    localparam int         SBUS_DATA_BITS   = 8;
    localparam int         SBUS_STOP_BITS   = 2;
    localparam int         SBUS_CH_W        = SBUS_NUM_CH * SBUS_CH_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } sbus_state_e;

    // Byte k of the frame; channel bytes are the packed channel vector read LSB first.
    function automatic logic [7:0] sbus_frame_byte(
        input logic [4:0]           idx,
        input logic [SBUS_CH_W-1:0] ch,
        input logic [3:0]           fl
    );
        logic [SBUS_CH_W-1:0] sh;
        logic [7:0]           b;
        sh = ch >> {idx - 5'd1, 3'b000};
        if (idx == 5'd0) begin
            b = SBUS_HEADER;
        end else if (idx <= 5'd22) begin
            b = sh[7:0];
        end else if (idx == 5'd23) begin
            b = {4'b0000, fl};
        end else begin
            b = SBUS_FOOTER;
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sbus_uart_tx.sv
// ============================================================================
// Module   : sbus_uart_tx
// Purpose  : 8E2 byte serialiser; takes the next byte on its last stop-bit cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sbus_uart_tx #(
    parameter int CYCLES_PER_BIT = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       txd
);

    localparam int              CW         = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0]   c_CNT_MAX  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]      c_LAST_BIT = 4'd11;

    logic          active_q, active_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   sh_q, sh_d;

    logic w_bit_end;
    logic w_last;
    logic w_load;

    assign w_bit_end  = active_q && (cnt_q == c_CNT_MAX);
    assign w_last     = w_bit_end && (bit_q == c_LAST_BIT);
    assign byte_ready = !active_q || w_last;
    assign w_load     = byte_valid && byte_ready;
    assign txd        = active_q ? sh_q[0] : 1'b1;

    // Shift register holds {stop, stop, parity, data[7:0], start}, sent LSB first.
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        if (w_load) begin
            active_d = 1'b1;
            bit_d    = 4'd0;
            cnt_d    = '0;
            sh_d     = {2'b11, ^byte_data, byte_data, 1'b0};
        end else if (active_q) begin
            if (w_bit_end) begin
                cnt_d = '0;
                sh_d  = {1'b1, sh_q[11:1]};
                if (w_last) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            cnt_q    <= '0;
            sh_q     <= '1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sbus_tx.sv
// ============================================================================
// Module   : sbus_tx
// Purpose  : S.Bus frame encoder/transmitter (25-byte frame, 8E2, inter-frame gap).
//            Define SBUS_TX_INVERT_EN for native inverted S.Bus line polarity.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sbus_tx
    import sbus_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BIT_RATE = 100000,
    parameter int GAP_BITS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [SBUS_CH_W-1:0] ch_data,
    input  logic [3:0]           flags,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 sbus_txd
);

    localparam int            CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int            c_GAP_CYC      = GAP_BITS * CYCLES_PER_BIT;
    localparam int            GW             = (c_GAP_CYC > 1) ? $clog2(c_GAP_CYC) : 1;
    localparam logic [GW-1:0] c_GAP_LOAD     = GW'((c_GAP_CYC > 0) ? (c_GAP_CYC - 1) : 0);
    localparam logic [4:0]    c_END_IDX      = 5'(SBUS_FRAME_BYTES);

`ifdef SBUS_TX_INVERT_EN
    localparam logic c_LINE_XOR = 1'b1;
`else
    localparam logic c_LINE_XOR = 1'b0;
`endif

    sbus_state_e          state_q, state_d;
    logic [4:0]           byte_idx_q, byte_idx_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [SBUS_CH_W-1:0] ch_q;
    logic [3:0]           flags_q;
    logic                 ready_q;
    logic                 end_q;
    logic                 done_q;
    logic                 txd_q;

    logic       w_accept;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic [7:0] w_byte_data;
    logic       w_frame_end;
    logic       w_uart_txd;

    assign w_accept     = frame_valid && ready_q;
    assign w_byte_valid = (state_q == ST_SEND) && (byte_idx_q < c_END_IDX);
    assign w_byte_data  = sbus_frame_byte(byte_idx_q, ch_q, flags_q);
    // All bytes handed over; the serialiser raising ready marks the footer's final cycle.
    assign w_frame_end  = (state_q == ST_SEND) && (byte_idx_q == c_END_IDX) && w_byte_ready;

    sbus_uart_tx #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_uart (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (w_byte_valid),
        .byte_ready (w_byte_ready),
        .byte_data  (w_byte_data),
        .txd        (w_uart_txd)
    );

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d    = ST_SEND;
                    byte_idx_d = 5'd0;
                end
            end
            ST_SEND: begin
                if (w_byte_valid && w_byte_ready) begin
                    byte_idx_d = byte_idx_q + 5'd1;
                end else if (w_frame_end) begin
                    if (GAP_BITS == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = c_GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line register adds one cycle, so frame_done is delayed two stages to align with the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 5'd0;
            gap_cnt_q  <= '0;
            ch_q       <= '0;
            flags_q    <= 4'd0;
            ready_q    <= 1'b0;
            end_q      <= 1'b0;
            done_q     <= 1'b0;
            txd_q      <= ~c_LINE_XOR;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            ready_q    <= (state_d == ST_IDLE);
            end_q      <= w_frame_end;
            done_q     <= end_q;
            txd_q      <= w_uart_txd ^ c_LINE_XOR;
            if (w_accept) begin
                ch_q    <= ch_data;
                flags_q <= flags;
            end
        end
    end

    assign frame_ready = ready_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign sbus_txd    = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_sbus_tx.sv
// ============================================================================
// Module   : tb_sbus_tx
// Purpose  : Scoreboard bench for sbus_tx; decodes the line back into bytes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sbus_tx;

    localparam int CLK_HZ    = 500000;
    localparam int BIT_RATE  = 100000;
    localparam int GAP_BITS  = 20;
    localparam int CPB       = CLK_HZ / BIT_RATE;
    localparam int BYTE_CYC  = 12 * CPB;
    localparam int FRAME_CYC = 25 * BYTE_CYC;
    localparam int GAP_CYC   = GAP_BITS * CPB;

`ifdef SBUS_TX_INVERT_EN
    localparam logic LINE_INV = 1'b1;
`else
    localparam logic LINE_INV = 1'b0;
`endif
    localparam logic IDLE_LVL = ~LINE_INV;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         frame_valid = 1'b0;
    logic [175:0] ch_data = '0;
    logic [3:0]   flags = 4'd0;
    logic         frame_ready;
    logic         busy;
    logic         frame_done;
    logic         sbus_txd;

    sbus_tx #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ch_data     (ch_data),
        .flags       (flags),
        .busy        (busy),
        .frame_done  (frame_done),
        .sbus_txd    (sbus_txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [1:0] stp;
        logic       glitch;
        int         start;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         done_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Line monitor: decodes 8E2 bytes, records start cycle and any mid-bit level change.
    initial begin : monitor
        logic        act;
        int          e;
        logic [11:0] bits;
        logic        line;
        logic        gl;
        int          st;
        rx_t         r;
        act = 1'b0; e = 0; bits = '0; gl = 1'b0; st = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b0) begin
                act = 1'b0;
            end else begin
                if (frame_done === 1'b1) done_q.push_back(cyc);
                line = sbus_txd ^ LINE_INV;
                if (!act) begin
                    if (line === 1'b0) begin
                        act = 1'b1; e = 0; bits = '0; gl = 1'b0; st = cyc;
                    end
                end else begin
                    e++;
                    if (e % CPB == 0) bits[e / CPB] = line;
                    else if (line !== bits[e / CPB]) gl = 1'b1;
                    if (e == BYTE_CYC - 1) begin
                        r.data = bits[8:1]; r.par = bits[9]; r.stp = bits[11:10];
                        r.glitch = gl; r.start = st;
                        rx_q.push_back(r);
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive_frame(input logic [175:0] ch, input logic [3:0] fl, input bit hold,
                               output int acc, output bit ok);
        @(negedge clk);
        ch_data = ch; flags = fl; frame_valid = 1'b1;
        ok = 1'b0; acc = -1;
        for (int w = 0; w < 200; w++) begin
            if (frame_ready === 1'b1) begin
                acc = cyc + 1; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            exp_q.push_back(8'h0F);
            for (int k = 1; k <= 22; k++) exp_q.push_back(ch[8*k-1 -: 8]);
            exp_q.push_back({4'b0000, fl});
            exp_q.push_back(8'h00);
        end
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            frame_valid = 1'b0;
        end
    endtask

    task automatic wait_rx(input int nbytes, input int ndone, output bit ok);
        ok = 1'b1;
        for (int w = 0; rx_q.size() < nbytes || done_q.size() < ndone; w++) begin
            if (w > 2 * FRAME_CYC + GAP_CYC + 200) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (sbus_txd !== IDLE_LVL || frame_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: txd=%b ready=%b busy=%b done=%b, need txd=%b ready=0 busy=0 done=0",
                     sbus_txd, frame_ready, busy, frame_done, IDLE_LVL);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, need 1", frame_ready);
        end
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sbus_txd !== IDLE_LVL || frame_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || rx_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_1000: bad cycles=%0d bytes=%0d dones=%0d, need 0/0/0", bad, rx_q.size(), done_q.size());
        end
    endtask

    task automatic test_frame_400();
        logic [175:0] ch;
        int acc;
        bit ok;
        rx_t r;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) ch[11*i +: 11] = 11'h400;
        drive_frame(ch, 4'd0, 1'b0, acc, ok);
        n_tests++;
        if (!ok || busy !== 1'b1 || frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL f400_accept: ok=%b busy=%b ready=%b, need 1/1/0", ok, busy, frame_ready);
        end
        wait_rx(25, 1, ok);
        for (int i = 0; i < 25; i++) begin
            n_tests++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL f400_byte%0d: no byte received (timeout=%b)", i, !ok);
                break;
            end
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e || r.par !== ^e || r.stp !== 2'b11 || r.glitch || r.start != acc + 2 + i * BYTE_CYC) begin
                n_fail++;
                $display("FAIL f400_byte%0d: got %h par=%b stp=%b gl=%b at %0d, need %h par=%b stp=11 at %0d",
                         i, r.data, r.par, r.stp, r.glitch, r.start, e, ^e, acc + 2 + i * BYTE_CYC);
            end
        end
        n_tests++;
        if (done_q.size() != 1 || done_q[0] != acc + 2 + FRAME_CYC) begin
            n_fail++;
            $display("FAIL f400_done: count=%0d first=%0d, need 1 at %0d", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, acc + 2 + FRAME_CYC);
        end
        done_q.delete();
        repeat (GAP_CYC + 10) @(negedge clk);
    endtask

    task automatic test_pattern_7ff();
        logic [175:0] ch;
        int acc;
        bit ok;
        rx_t r;
        logic [7:0] e;
        ch = '0;
        ch[10:0] = 11'h7FF;
        drive_frame(ch, 4'b1010, 1'b0, acc, ok);
        wait_rx(25, 1, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL p7ff_timeout: bytes=%0d dones=%0d, need 25/1", rx_q.size(), done_q.size());
        end
        for (int i = 0; i < 25 && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            n_tests++;
            if (r.data !== e || r.par !== ^e || r.stp !== 2'b11 || r.glitch) begin
                n_fail++;
                $display("FAIL p7ff_byte%0d: got %h par=%b stp=%b gl=%b, need %h par=%b stp=11",
                         i, r.data, r.par, r.stp, r.glitch, e, ^e);
            end
            if (i == 1 || i == 2 || i == 23) begin
                n_tests++;
                if ((i == 1 && (r.data !== 8'hFF || r.par !== 1'b0)) ||
                    (i == 2 && (r.data !== 8'h07 || r.par !== 1'b1)) ||
                    (i == 23 && r.data !== 8'h0A)) begin
                    n_fail++;
                    $display("FAIL p7ff_const%0d: got %h par=%b", i, r.data, r.par);
                end
            end
        end
        done_q.delete();
        repeat (GAP_CYC + 10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [191:0] rnd;
        logic [3:0]   fl;
        int acc1, acc2, busy_bad;
        bit ok;
        rx_t r;
        logic [7:0] e;
        for (int w = 0; w < 6; w++) rnd[32*w +: 32] = $urandom;
        fl = 4'($urandom_range(0, 15));
        drive_frame(rnd[175:0], fl, 1'b1, acc1, ok);
        acc2 = -1; busy_bad = 0;
        for (int w = 0; w < FRAME_CYC + GAP_CYC + 50; w++) begin
            @(negedge clk);
            if (frame_ready === 1'b1) begin
                acc2 = cyc + 1;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        if (acc2 >= 0) begin
            exp_q.push_back(8'h0F);
            for (int k = 1; k <= 22; k++) exp_q.push_back(rnd[8*k-1 -: 8]);
            exp_q.push_back({4'b0000, fl});
            exp_q.push_back(8'h00);
        end
        n_tests++;
        if (!ok || acc2 != acc1 + 2 + FRAME_CYC + GAP_CYC || busy !== 1'b0 || busy_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_accept: second accept at %0d, need %0d; busy=%b busy_bad=%0d",
                     acc2, acc1 + 2 + FRAME_CYC + GAP_CYC, busy, busy_bad);
        end
        @(posedge clk);
        @(negedge clk);
        frame_valid = 1'b0;
        wait_rx(50, 2, ok);
        for (int i = 0; i < 50; i++) begin
            n_tests++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: no byte received (timeout=%b)", i, !ok);
                break;
            end
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e || r.par !== ^e || r.stp !== 2'b11 || r.glitch ||
                r.start != ((i < 25) ? acc1 : acc2) + 2 + (i % 25) * BYTE_CYC) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got %h par=%b stp=%b gl=%b at %0d, need %h par=%b at %0d",
                         i, r.data, r.par, r.stp, r.glitch, r.start, e, ^e,
                         ((i < 25) ? acc1 : acc2) + 2 + (i % 25) * BYTE_CYC);
            end
        end
        n_tests++;
        if (done_q.size() != 2 || done_q[0] != acc1 + 2 + FRAME_CYC || done_q[1] != acc2 + 2 + FRAME_CYC) begin
            n_fail++;
            $display("FAIL b2b_done: count=%0d, need 2 at %0d and %0d", done_q.size(),
                     acc1 + 2 + FRAME_CYC, acc2 + 2 + FRAME_CYC);
        end
        done_q.delete();
        repeat (GAP_CYC + 10) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [191:0] rnd;
        int acc, acc2, target;
        bit ok;
        rx_t r;
        logic [7:0] e;
        for (int w = 0; w < 6; w++) rnd[32*w +: 32] = $urandom;
        drive_frame(rnd[175:0], 4'b0101, 1'b0, acc, ok);
        target = acc + 2 + 7 * BYTE_CYC + 3 * CPB;
        while (cyc < target) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sbus_txd !== IDLE_LVL || busy !== 1'b0 || frame_ready !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: txd=%b busy=%b ready=%b done=%b, need %b/0/0/0",
                     sbus_txd, busy, frame_ready, frame_done, IDLE_LVL);
        end
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        n_tests++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b, need 1", frame_ready);
        end
        drive_frame(rnd[191:16], 4'b0011, 1'b0, acc2, ok);
        wait_rx(25, 1, ok);
        for (int i = 0; i < 25; i++) begin
            n_tests++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL midrst_byte%0d: no byte received (timeout=%b)", i, !ok);
                break;
            end
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e || r.par !== ^e || r.stp !== 2'b11 || r.glitch || r.start != acc2 + 2 + i * BYTE_CYC) begin
                n_fail++;
                $display("FAIL midrst_byte%0d: got %h par=%b stp=%b gl=%b at %0d, need %h par=%b at %0d",
                         i, r.data, r.par, r.stp, r.glitch, r.start, e, ^e, acc2 + 2 + i * BYTE_CYC);
            end
        end
        n_tests++;
        if (done_q.size() != 1 || done_q[0] != acc2 + 2 + FRAME_CYC) begin
            n_fail++;
            $display("FAIL midrst_done: count=%0d first=%0d, need 1 at %0d", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, acc2 + 2 + FRAME_CYC);
        end
        done_q.delete();
    endtask

    initial begin : main
        test_reset();
        test_frame_400();
        test_pattern_7ff();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
